// File: rtl/serial_operand_driver.sv
// Serial operand driver: shifts two operands LSB first into a serial
// adder and collects the returned sum and carry into a parallel result.
module serial_operand_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             out_A,
    output logic             out_B,
    output logic             frame,
    output logic             first,
    input  logic             sum_in,
    input  logic             cout_in,
    output logic [WIDTH:0]   result,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             out_a_q, out_a_d;
    logic             out_b_q, out_b_d;
    logic             frame_q, frame_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    // Next-state and next-output logic; serial outputs are precomputed
    // one cycle ahead so every output leaves straight from a flop.
    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        out_a_d  = 1'b0;
        out_b_d  = 1'b0;
        frame_d  = 1'b0;
        first_d  = 1'b0;
        done_d   = 1'b0;
        ready_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    state_d = SHIFT;
                    ready_d = 1'b0;
                    sh_a_d  = {1'b0, op_a[WIDTH-1:1]};
                    sh_b_d  = {1'b0, op_b[WIDTH-1:1]};
                    out_a_d = op_a[0];
                    out_b_d = op_b[0];
                    frame_d = 1'b1;
                    first_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // The adder's sum lags by one cycle, so nothing valid
                // arrives until the second shift cycle.
                if (cnt_q != '0) begin
                    cap_d = {sum_in, cap_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    out_a_d = sh_a_q[0];
                    out_b_d = sh_b_q[0];
                    sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
                    sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
                    frame_d = 1'b1;
                end
            end
            DRAIN: begin
                cap_d    = {sum_in, cap_q[WIDTH-1:1]};
                result_d = {cout_in, sum_in, cap_q[WIDTH-1:1]};
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            cap_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            out_a_q  <= 1'b0;
            out_b_q  <= 1'b0;
            frame_q  <= 1'b0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            out_a_q  <= out_a_d;
            out_b_q  <= out_b_d;
            frame_q  <= frame_d;
            first_q  <= first_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign out_A  = out_a_q;
    assign out_B  = out_b_q;
    assign frame  = frame_q;
    assign first  = first_q;
    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_operand_driver.sv
// Bench for serial_operand_driver: drives transfers against a serial
// adder model and checks cycle timing and results against a + b.
module tb_serial_operand_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         ready;
    logic         out_A;
    logic         out_B;
    logic         frame;
    logic         first;
    logic         sum_in;
    logic         cout_in;
    logic [W:0]   result;
    logic         done;

    int errors = 0;
    int checks = 0;

    serial_operand_driver #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .ready   (ready),
        .out_A   (out_A),
        .out_B   (out_B),
        .frame   (frame),
        .first   (first),
        .sum_in  (sum_in),
        .cout_in (cout_in),
        .result  (result),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Serial adder with a one-cycle registered sum and carry.
    logic sum_r;
    logic c_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= 1'b0;
            c_r   <= 1'b0;
        end else if (frame) begin
            {c_r, sum_r} <= 2'(out_A) + 2'(out_B) + 2'(first ? 1'b0 : c_r);
        end
    end
    assign sum_in  = sum_r;
    assign cout_in = c_r;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge with the DUT idle; returns at the falling
    // edge of the next idle cycle so transfers chain back to back.
    task automatic xfer(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit scramble);
        logic [W:0] exp_res;
        exp_res = (W+1)'(a) + (W+1)'(b);
        check("ready_idle", 32'(ready), 32'd1);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (scramble) begin
                op_a = W'($urandom);
                op_b = W'($urandom);
            end
            check("out_A", 32'(out_A), 32'(a[k]));
            check("out_B", 32'(out_B), 32'(b[k]));
            check("frame", 32'(frame), 32'd1);
            check("first", 32'(first), 32'(k == 0));
            check("ready_busy", 32'(ready), 32'd0);
            check("done_early", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("drain_frame", 32'(frame), 32'd0);
        check("drain_outs", 32'({out_A, out_B, first}), 32'd0);
        check("drain_done", 32'(done), 32'd0);
        check("drain_ready", 32'(ready), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_ready", 32'(ready), 32'd0);
        check("result", 32'(result), 32'(exp_res));
        check("done_frame", 32'(frame), 32'd0);
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("result_hold", 32'(result), 32'(exp_res));
        if (!hold) start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_outs", 32'({out_A, out_B, frame, first, done}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        xfer(8'h05, 8'h03, 1'b0, 1'b0);
        xfer(8'hFF, 8'h01, 1'b0, 1'b0);
        xfer(8'hA5, 8'h3C, 1'b0, 1'b0);
        // Continuous start: each transfer re-accepted every W+3 cycles.
        xfer(8'h7E, 8'h81, 1'b1, 1'b0);
        xfer(8'hC3, 8'h5A, 1'b1, 1'b0);
        start = 1'b0;
        // Operands wander while busy.
        xfer(8'h12, 8'h34, 1'b0, 1'b1);

        for (int n = 0; n < 12; n++) begin
            xfer(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        start = 1'b0;

        // Abort mid-shift at bit 4.
        op_a  = 8'hEE;
        op_b  = 8'h77;
        start = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_abort_frame", 32'(frame), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_outs", 32'({out_A, out_B, frame, first, done}), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(ready), 32'd1);
        end
        xfer(8'h10, 8'h20, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
